// File: rtl/stream_to_memory.sv
// stream_to_memory: collects a posit word stream into a MEMORY_DEPTH-entry frame and presents it in parallel.
// Define STREAM_TO_MEMORY_PINGPONG_EN for two banks; by default a single bank is used.
module stream_to_memory #(
  parameter int DATA_WIDTH   = 16,
  parameter int MEMORY_DEPTH = 20,
  parameter int CNT_W        = $clog2(MEMORY_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  rtr_o,
  input  logic                  rts_i,
  input  logic                  eow_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  rtr_i,
  output logic                  rts_o,
  output logic                  eow_o,
  output logic [CNT_W-1:0]      count_o,
  output logic [DATA_WIDTH-1:0] data_o [MEMORY_DEPTH]
);
`ifdef STREAM_TO_MEMORY_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  localparam int AW = $clog2(MEMORY_DEPTH);
  typedef enum logic [1:0] {EMPTY, FILLING, FULL} state_t;
  state_t                state [NB];
  logic [DATA_WIDTH-1:0] mem   [NB][MEMORY_DEPTH];
  logic [CNT_W-1:0]      cnt   [NB];
  logic                  tlast [NB];
  logic [CNT_W-1:0]      wc;
  logic                  wb, rb;
  logic                  acc, rel, last;
  assign rtr_o   = state[wb] != FULL;
  assign rts_o   = state[rb] == FULL;
  assign eow_o   = tlast[rb];
  assign count_o = cnt[rb];
  assign data_o  = mem[rb];
  assign acc     = rts_i & rtr_o;
  assign rel     = rts_o & rtr_i;
  assign last    = (wc == CNT_W'(MEMORY_DEPTH - 1)) | eow_i;
`ifdef STREAM_TO_MEMORY_PINGPONG_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wb <= 1'b0;
      rb <= 1'b0;
    end else begin
      if (acc && last) wb <= ~wb;
      if (rel) rb <= ~rb;
    end
`else
  assign wb = 1'b0;
  assign rb = 1'b0;
`endif
  // Release clears the bank so short frames read zero beyond their count.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wc <= '0;
      for (int b = 0; b < NB; b++) begin
        state[b] <= EMPTY;
        tlast[b] <= 1'b0;
        cnt[b]   <= '0;
        for (int i = 0; i < MEMORY_DEPTH; i++) mem[b][i] <= '0;
      end
    end else begin
      if (rel) begin
        state[rb] <= EMPTY;
        tlast[rb] <= 1'b0;
        cnt[rb]   <= '0;
        for (int i = 0; i < MEMORY_DEPTH; i++) mem[rb][i] <= '0;
      end
      if (acc) begin
        mem[wb][wc[AW-1:0]] <= data_i;
        state[wb]           <= last ? FULL : FILLING;
        wc                  <= last ? '0 : wc + 1'b1;
        if (last) begin
          tlast[wb] <= eow_i;
          cnt[wb]   <= wc + 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_stream_to_memory.sv
// tb_stream_to_memory: scoreboard bench for stream_to_memory with MEMORY_DEPTH=4.
module tb_stream_to_memory;
`ifdef STREAM_TO_MEMORY_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  typedef struct packed {
    logic [3:0][15:0] d;
    logic [2:0]       cnt;
    logic             eow;
  } frame_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rtr_o, rts_i = 1'b0, eow_i = 1'b0, rtr_i = 1'b0, rts_o, eow_o;
  logic [15:0] data_i = '0;
  logic [2:0]  count_o;
  logic [15:0] data_o [4];
  int          checks = 0, fails = 0;
  frame_t      q [$];
  frame_t      cur = '0;
  frame_t      pf = '0;
  int          wc = 0;
  logic        prv_rts = 1'b0, prv_rtr = 1'b0;
  logic [15:0] nxt = 16'h0100;

  stream_to_memory #(.DATA_WIDTH(16), .MEMORY_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .rtr_o(rtr_o), .rts_i(rts_i), .eow_i(eow_i), .data_i(data_i),
    .rtr_i(rtr_i), .rts_o(rts_o), .eow_o(eow_o), .count_o(count_o), .data_o(data_o)
  );

  always #5 clk = ~clk;

  function automatic frame_t observed();
    frame_t f;
    for (int i = 0; i < 4; i++) f.d[i] = data_o[i];
    f.cnt = count_o;
    f.eow = eow_o;
    return f;
  endfunction

  // One clock: drive at posedge+1, check and update the model at negedge.
  task automatic step(input logic v, input logic e, input logic [15:0] d, input logic r, output logic acc);
    frame_t af, ef;
    logic   exp_rtr;
    rts_i = v; eow_i = e; data_i = d; rtr_i = r;
    @(negedge clk);
    af = observed();
    exp_rtr = q.size() < NB;
    checks++;
    if (rts_o !== (q.size() > 0)) begin
      fails++;
      $display("FAIL rts_o: got %b expected %b at %0t", rts_o, q.size() > 0, $time);
    end
    checks++;
    if (rtr_o !== exp_rtr) begin
      fails++;
      $display("FAIL rtr_o: got %b expected %b at %0t", rtr_o, exp_rtr, $time);
    end
    if (prv_rts && !prv_rtr) begin
      checks++;
      if (rts_o !== 1'b1 || af !== pf) begin
        fails++;
        $display("FAIL hold: rts_o %b frame %h expected frame %h held", rts_o, af, pf);
      end
    end
    if (q.size() > 0 && r) begin
      ef = q.pop_front();
      checks++;
      if (af !== ef) begin
        fails++;
        $display("FAIL frame: got %h expected %h at %0t", af, ef, $time);
      end
    end
    acc = v && exp_rtr;
    if (acc) begin
      cur.d[wc] = d;
      if (wc == 3 || e) begin
        cur.cnt = 3'(wc + 1);
        cur.eow = e;
        q.push_back(cur);
        cur = '0;
        wc = 0;
      end else wc++;
    end
    prv_rts = rts_o;
    prv_rtr = r;
    pf = af;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic e);
    logic a;
    int   n;
    a = 1'b0;
    n = 0;
    while (!a && n < 100) begin
      step(1'b1, e, d, 1'b1, a);
      n++;
    end
    checks++;
    if (!a) begin
      fails++;
      $display("FAIL send_timeout: word %h accepted %b expected 1", d, a);
    end
  endtask

  task automatic idle(input int n);
    logic a;
    repeat (n) step(1'b0, 1'b0, 16'h0, 1'b1, a);
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (observed() !== '0 || rtr_o !== 1'b1 || rts_o !== 1'b0) begin
      fails++;
      $display("FAIL %s: frame %h rtr_o %b rts_o %b expected frame 0 rtr_o 1 rts_o 0", tag, observed(), rtr_o, rts_o);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_values");
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_full_frame();
    send(16'h1111, 1'b0);
    send(16'h2222, 1'b0);
    send(16'h3333, 1'b0);
    send(16'h4444, 1'b0);
    idle(3);
  endtask

  task automatic test_short_frame();
    send(16'hA001, 1'b0);
    send(16'hA002, 1'b1);
    idle(2);
    send(16'hB001, 1'b1);
    idle(3);
  endtask

  task automatic test_backpressure();
    logic a;
    int   got, n;
    for (int i = 0; i < 4; i++) send(16'hC000 + 16'(i), 1'b0);
    got = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, nxt, 1'b0, a);
      if (a) begin nxt++; got++; end
    end
    n = 0;
    while (got < 4 && n < 100) begin
      step(1'b1, 1'b0, nxt, 1'b1, a);
      if (a) begin nxt++; got++; end
      n++;
    end
    checks++;
    if (got != 4) begin
      fails++;
      $display("FAIL backpressure_timeout: accepted %0d expected 4", got);
    end
    idle(4);
  endtask

  task automatic test_eow_last();
    send(16'hD001, 1'b0);
    send(16'hD002, 1'b0);
    send(16'hD003, 1'b0);
    send(16'hD004, 1'b1);
    idle(4);
  endtask

  task automatic test_reset_mid();
    send(16'hE001, 1'b0);
    send(16'hE002, 1'b0);
    rst_n = 1'b0;
    q.delete();
    cur = '0;
    wc = 0;
    prv_rts = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset_mid");
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(16'hF001, 1'b0);
    send(16'hF002, 1'b0);
    send(16'hF003, 1'b0);
    send(16'hF004, 1'b0);
    idle(3);
  endtask

  task automatic test_random();
    logic a, v, e;
    int   words, n;
    words = 0;
    n = 0;
    while (words < 1000 && n < 20000) begin
      v = 1'($urandom_range(0, 1));
      e = ($urandom_range(0, 7) == 0);
      step(v, e, nxt, 1'($urandom_range(0, 1)), a);
      if (a) begin nxt++; words++; end
      n++;
    end
    checks++;
    if (words < 1000) begin
      fails++;
      $display("FAIL random_timeout: accepted %0d expected 1000", words);
    end
    send(nxt, 1'b1);
    n = 0;
    while (q.size() > 0 && n < 50) begin
      idle(1);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d frames left expected 0", q.size());
    end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_short_frame();
    test_backpressure();
    test_eow_last();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
